// File: rtl/mutative_mem_arbiter.sv
// mutative_mem_arbiter: round-robin two-port line memory arbiter; optional BUSY timeout via MEM_ARB_TIMEOUT_EN
module mutative_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_read,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*LINE_W-1:0] req_wdata,
  output logic [1:0]          resp,
  output logic [LINE_W-1:0]   rdata,
  output logic [1:0]          grant,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [LINE_W-1:0]   mem_wdata,
  input  logic [LINE_W-1:0]   mem_rdata,
  input  logic                mem_resp,
  output logic                timeout_err
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  state_e state_q, state_d;
  logic win_q, win_d, wr_q, wr_d, last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0] req;
  logic pick, busy, expire;
  assign req  = req_read | req_write;
  assign pick = &req ? ~last_q : req[1];
  assign busy = state_q == BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic tmo_q;
  assign expire      = busy && !mem_resp && cnt_q == CW'(TIMEOUT - 1);
  assign timeout_err = tmo_q;
  // Count unanswered BUSY cycles and keep a sticky error once the limit is hit
  always_ff @(posedge clk)
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= busy ? cnt_q + 1'b1 : '0;
      tmo_q <= tmo_q | expire;
    end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expire         = 1'b0;
  assign timeout_err    = 1'b0;
`endif
  // Arbitrate and latch in IDLE, wait for memory in BUSY, pulse the response in RESP
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    wr_d    = wr_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (state_q == IDLE && |req) begin
      state_d = BUSY;
      win_d   = pick;
      wr_d    = pick ? req_write[1] : req_write[0];
      addr_d  = pick ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
      wdata_d = pick ? req_wdata[2*LINE_W-1:LINE_W] : req_wdata[LINE_W-1:0];
    end
    if (busy && (mem_resp || expire)) begin
      state_d = RESP;
      rdata_d = mem_resp ? mem_rdata : '0;
      last_d  = win_q;
    end
    if (state_q == RESP) state_d = IDLE;
  end
  // State and latched-request registers; last starts at 1 so port 0 wins the first tie
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      wr_q    <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      wr_q    <= wr_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  assign grant     = state_q == IDLE ? 2'b00 : {win_q, ~win_q};
  assign resp      = state_q == RESP ? {win_q, ~win_q} : 2'b00;
  assign rdata     = rdata_q;
  assign mem_read  = busy & ~wr_q;
  assign mem_write = busy & wr_q;
  assign mem_addr  = busy ? addr_q : '0;
  assign mem_wdata = busy ? wdata_q : '0;
endmodule

// File: tb/tb_mutative_mem_arbiter.sv
// tb_mutative_mem_arbiter: directed and randomized checks of mutative_mem_arbiter against a transaction-level model
module tb_mutative_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int TO = 8;
  logic clk, rst;
  logic [1:0] req_read, req_write, resp, grant;
  logic [2*AW-1:0] req_addr;
  logic [2*LW-1:0] req_wdata;
  logic [LW-1:0] rdata, mem_wdata, mem_rdata;
  logic mem_read, mem_write, mem_resp, timeout_err;
  logic [AW-1:0] mem_addr;
  int checks = 0, fails = 0;
  bit rnd_mode = 0, mem_auto = 1;
  int lat = 3;
  logic [LW-1:0] fixed_data;
  mutative_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp(resp), .rdata(rdata),
    .grant(grant), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .timeout_err(timeout_err)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  function automatic logic [LW-1:0] r256();
    logic [LW-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction
  function automatic int winner(bit r0, bit r1, int last);
    return (r0 && r1) ? 1 - last : (r0 ? 0 : 1);
  endfunction
  // Transaction-level model: phase 0 idle, 1 memory command out, 2 response pulse
  int m_ph = 0, m_win = 0, m_last = 1, m_cnt = 0, mw;
  bit m_wr = 0, m_tmo = 0, m_on = 0;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata, m_rdata;
  assign mw = winner(req_read[0] | req_write[0], req_read[1] | req_write[1], m_last);
  always @(posedge clk) begin
    m_on <= 1;
    if (rst) begin
      m_ph <= 0; m_last <= 1; m_rdata <= '0; m_tmo <= 0; m_cnt <= 0;
    end else if (m_ph == 2) m_ph <= 0;
    else if (m_ph == 1) begin
      m_cnt <= m_cnt + 1;
      if (mem_resp) begin
        m_ph <= 2; m_rdata <= mem_rdata; m_last <= m_win;
      end
`ifdef MEM_ARB_TIMEOUT_EN
      else if (m_cnt == TO - 1) begin
        m_ph <= 2; m_rdata <= '0; m_last <= m_win; m_tmo <= 1;
      end
`endif
    end else if (|(req_read | req_write)) begin
      m_ph <= 1; m_cnt <= 0; m_win <= mw; m_wr <= req_write[mw];
      m_addr <= req_addr[mw*AW +: AW]; m_wdata <= req_wdata[mw*LW +: LW];
    end
  end
  // Compare every cycle against the model
  initial forever @(negedge clk) if (m_on) begin
    logic [1:0] oh;
    oh = m_win == 1 ? 2'b10 : 2'b01;
    chk("grant", grant, m_ph != 0 ? oh : 2'b00);
    chk("resp", resp, m_ph == 2 ? oh : 2'b00);
    chk("mem_read", mem_read, m_ph == 1 && !m_wr);
    chk("mem_write", mem_write, m_ph == 1 && m_wr);
    chk("timeout_err", timeout_err, m_tmo);
    if (m_ph == 1) chk("mem_addr", mem_addr, m_addr);
    if (m_ph == 1 && m_wr) chk("mem_wdata", mem_wdata, m_wdata);
    if (m_ph == 2) chk("rdata", rdata, m_rdata);
  end
  // Memory responder: fixed latency in directed mode, random latency and stray responses otherwise
  initial begin
    int wcnt = 0;
    mem_resp = 0;
    mem_rdata = '0;
    forever @(negedge clk) begin
      mem_resp = 0;
      if (mem_read || mem_write) begin
        if (mem_auto && (rnd_mode ? $urandom_range(0, 2) == 0 : wcnt == lat)) begin
          mem_resp = 1;
          mem_rdata = rnd_mode ? r256() : fixed_data;
        end
        wcnt++;
      end else begin
        wcnt = 0;
        if (rnd_mode && $urandom_range(0, 9) == 0) begin
          mem_resp = 1;
          mem_rdata = r256();
        end
      end
    end
  end
  function automatic bit cond(int k);
    return k == 0 ? resp[0] : k == 1 ? resp[1] : k == 2 ? mem_read : mem_write;
  endfunction
  task automatic wait_for(input int k, input string nm);
    int i = 0;
    while (!cond(k) && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk(nm, cond(k), 1);
  endtask
  task automatic pulse_rst();
    req_read = 0; req_write = 0; rst = 1;
    @(negedge clk);
    rst = 0;
  endtask
  task automatic new_req(input int p);
    int op = $urandom_range(0, 2);
    req_read[p] = op != 1;
    req_write[p] = op != 0;
    req_addr[p*AW +: AW] = $urandom;
    req_wdata[p*LW +: LW] = r256();
  endtask
  initial begin
    int ord[4];
    int nord, n;
    rst = 1; req_read = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    fixed_data = {32{8'hA5}};
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0); chk("rst_resp", resp, 0); chk("rst_rdata", rdata, 0);
    chk("rst_mem_read", mem_read, 0); chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_timeout_err", timeout_err, 0);
    // single read with 3-cycle memory latency and an address change while busy
    rst = 0; lat = 3;
    req_read[0] = 1; req_addr[AW-1:0] = 32'h0000_1040;
    @(negedge clk);
    chk("rd_mem_read_c1", mem_read, 1); chk("rd_mem_addr_c1", mem_addr, 32'h1040);
    chk("rd_grant_c1", grant, 2'b01);
    req_addr[AW-1:0] = 32'hDEAD_0000;
    repeat (2) begin
      @(negedge clk);
      chk("rd_mem_addr_held", mem_addr, 32'h1040);
    end
    @(negedge clk);
    chk("rd_mem_read_c4", mem_read, 1);
    @(negedge clk);
    chk("rd_resp_c5", resp, 2'b01); chk("rd_rdata_c5", rdata, {32{8'hA5}});
    chk("rd_cmd_dropped", mem_read, 0);
    req_read[0] = 0;
    @(negedge clk);
    chk("rd_grant_idle", grant, 2'b00);
    // simultaneous continuous requests from reset alternate 0,1,0,1
    rst = 1; req_read = 2'b11; lat = 0;
    @(negedge clk);
    rst = 0;
    ord = '{3, 3, 3, 3};
    nord = 0;
    for (int i = 0; i < 60 && nord < 4; i++) begin
      @(negedge clk);
      if (resp != 0) begin
        ord[nord] = int'(resp[1]);
        nord++;
      end
    end
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), ord[i], i % 2);
    pulse_rst();
    // write-back then refill on port 1
    lat = 1; fixed_data = {8{32'hCAFE_F00D}};
    req_write[1] = 1; req_addr[2*AW-1:AW] = 32'h2000; req_wdata[2*LW-1:LW] = {8{32'h1234_5678}};
    wait_for(3, "wb_mem_write_seen");
    chk("wb_mem_addr", mem_addr, 32'h2000); chk("wb_mem_wdata", mem_wdata, {8{32'h1234_5678}});
    wait_for(1, "wb_resp_seen");
    req_write[1] = 0; req_read[1] = 1; req_addr[2*AW-1:AW] = 32'h3000;
    wait_for(2, "rf_mem_read_seen");
    chk("rf_mem_addr", mem_addr, 32'h3000); chk("rf_mem_write", mem_write, 0);
    wait_for(1, "rf_resp_seen");
    chk("rf_rdata", rdata, {8{32'hCAFE_F00D}});
    pulse_rst();
    // reset while busy, then the still-held request is served normally
    lat = 10;
    req_read[0] = 1; req_addr[AW-1:0] = 32'h5000;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("mr_grant", grant, 0); chk("mr_resp", resp, 0); chk("mr_mem_read", mem_read, 0);
    chk("mr_mem_addr", mem_addr, 0); chk("mr_timeout_err", timeout_err, 0);
    rst = 0; lat = 1;
    wait_for(0, "mr_resp_after");
    chk("mr_rdata", rdata, {8{32'hCAFE_F00D}});
    pulse_rst();
`ifdef MEM_ARB_TIMEOUT_EN
    // memory never answers: command drops after TO busy cycles
    mem_auto = 0;
    req_read[0] = 1; req_addr[AW-1:0] = 32'h7000;
    wait_for(2, "to_mem_read_seen");
    n = 0;
    while (mem_read && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("to_busy_cycles", n, TO);
    chk("to_resp", resp, 2'b01); chk("to_rdata", rdata, 0); chk("to_err", timeout_err, 1);
    req_read[0] = 0;
    repeat (5) @(negedge clk);
    chk("to_err_sticky", timeout_err, 1);
    rst = 1;
    @(negedge clk);
    chk("to_err_cleared", timeout_err, 0);
    rst = 0; mem_auto = 1;
`endif
    // randomized traffic with stray memory responses, mid-grant request changes and reset pulses
    rnd_mode = 1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = $urandom_range(0, 299) == 0;
      for (int p = 0; p < 2; p++) begin
        if (resp[p]) begin
          if ($urandom_range(0, 1) == 0) new_req(p);
          else begin
            req_read[p] = 0;
            req_write[p] = 0;
          end
        end else if (!(req_read[p] | req_write[p])) begin
          if ($urandom_range(0, 3) == 0) new_req(p);
        end else if (grant[p] && $urandom_range(0, 3) == 0) begin
          req_addr[p*AW +: AW] = $urandom;
          req_wdata[p*LW +: LW] = r256();
        end
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
